block_interleaver: RTL and testbench
====================================

Name: block_interleaver

Overview:
- Serial-bit block interleaver on the transmit side; the deinterleaver at the receiver inverts it exactly.
- Input bits are written row-major into a ROWS x COLS bit array and read out column-major.
- Two ping-pong banks: one bank fills while the other drains. This gives continuous throughput of 1 bit/clk after the first block.
- Sits between the channel encoder output and the modulator bit input.

Parameters:
ROWS, 4, number of rows in the interleaver array (>=2)
COLS, 4, number of columns in the interleaver array (>=2)
N (localparam), ROWS*COLS, bits per block
CW (localparam), $clog2(N), index counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  in_bit is presented this cycle; no backpressure without INTLV_FLUSH_EN
in_bit  input  1  serial data bit
out_valid  output  1  out_bit/out_sof are meaningful this cycle
out_bit  output  1  interleaved serial bit
out_sof  output  1  high with the first bit (index 0) of each output block
primed  output  1  high once at least one full block has been stored

Behaviour:
- Reset: rst=0 asynchronously clears both banks, wcnt=0, wsel=0, state=EMPTY, out_valid=0, out_bit=0, out_sof=0, primed=0. A reset mid-block discards all partial and stored data.
- Internal state: bank0[N], bank1[N]; wsel selects the write bank; the read bank is !wsel; wcnt (CW bits) is shared by write and read because they run in lockstep.
- Write address = wcnt (row-major: r*COLS+c).
- Read address for output index k=wcnt: (k % ROWS)*COLS + (k / ROWS), which is column-major. For ROWS=COLS=4 the read order is 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- FSM states: EMPTY (no complete block stored), STREAM (read bank holds a complete block).
- On clk edge with in_valid=1:
  - write bank[wsel][wcnt] <= in_bit.
  - In STREAM: out_bit <= readbank[raddr(wcnt)], out_valid <= 1, out_sof <= (wcnt==0).
  - In EMPTY: out_valid <= 0, out_sof <= 0.
  - If wcnt==N-1: wcnt <= 0, wsel <= !wsel, state <= STREAM, primed <= 1. Otherwise wcnt <= wcnt+1.
- On clk edge with in_valid=0: all state held, out_valid <= 0, out_sof <= 0, out_bit holds its last value. Gaps stall the pipeline; they do NOT reset it.
- Outputs are registered. Latency: input bit accepted at valid-cycle j emerges on a valid-cycle in the next block, 1 clk after the accepting edge of the corresponding later input.
- Bank-swap boundary: on the edge accepting bit N-1, the read of index N-1 from the old read bank completes in the same edge as the swap. The next valid cycle reads index 0 of the newly filled bank, so output is gapless.
- STREAM is never exited except by reset, or by DRAIN completion (optional feature).

Optional Feature:
- Macro: INTLV_FLUSH_EN.
- Defined:
  - Adds input port flush (1b) and output port in_ready (1b).
  - Adds states FLUSH and DRAIN.
  - in_ready=1 only in EMPTY/STREAM.
  - flush=1 with wcnt!=0 enters FLUSH. FLUSH writes 0 padding bits one per clk, independent of in_valid, while still emitting the read bank if it held a full block, until wcnt wraps; then it enters DRAIN.
  - flush=1 with wcnt==0 enters DRAIN directly if primed, otherwise stays EMPTY.
  - DRAIN outputs the last stored block, 1 bit/clk, with out_valid=1, then returns to EMPTY with primed=0.
  - in_valid is ignored while in_ready=0.
- Undefined: no flush or in_ready ports; the final block is only emitted by pushing N more input bits.

Test Plan:
- Reset then 16 valid bits 0..15 with only bit index 1 =1 -> out_valid stays 0 during block 1. Block 2 (all zeros in) yields out_bit=1 only at output index 4, and out_sof=1 at output index 0.
- Two back-to-back blocks, 0xA5C3 then 0xFFFF (bit i = LSB-first) -> block-2 input window outputs the column-major permutation of 0xA5C3 with no out_valid gap at the swap edge.
- in_valid toggled 1,0,1,0 across a block -> output sequence identical to the continuous case. out_valid=0 on each idle cycle, and wcnt/banks unchanged.
- Assert rst at input index 7 of block 3 -> all outputs 0 immediately. The next 16 bits produce no out_valid; primed=0 until wcnt wraps.
- ROWS=2, COLS=8, index pattern input -> read order 0,8,1,9,...,7,15.
- With INTLV_FLUSH_EN: 5 bits then flush=1 -> in_ready=0 for 11 pad cycles plus 16 drain cycles. The output block holds the 5 bits at their permuted positions and zeros elsewhere; the FSM then returns to EMPTY.

Source files
------------

// File: rtl/block_interleaver.sv
// block_interleaver: ping-pong ROWSxCOLS bit interleaver, written row-major and read column-major.
// Optional flush/drain of a partial final block when INTLV_FLUSH_EN is defined.
module block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
`ifdef INTLV_FLUSH_EN
  input  logic flush,
  output logic in_ready,
`endif
  output logic out_valid,
  output logic out_bit,
  output logic out_sof,
  output logic primed
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N);
`ifdef INTLV_FLUSH_EN
  typedef enum logic [1:0] {EMPTY, STREAM, FLUSH, DRAIN} state_t;
`else
  typedef enum logic {EMPTY, STREAM} state_t;
`endif
  state_t state_q, state_d;
  logic [1:0][N-1:0] bank_q, bank_d;
  logic [CW-1:0] wcnt_q, wcnt_d, raddr;
  logic wsel_q, wsel_d, primed_q, primed_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_sof_q, out_sof_d;
  logic wr, wbit, emit, adv, last;
  assign raddr = CW'((int'(wcnt_q) % ROWS) * COLS + int'(wcnt_q) / ROWS);
  assign last = wcnt_q == CW'(N - 1);
`ifdef INTLV_FLUSH_EN
  assign in_ready = state_q == EMPTY || state_q == STREAM;
`endif
  always_comb begin
    wr = in_valid;
    wbit = in_bit;
    emit = in_valid && state_q == STREAM;
    adv = in_valid;
`ifdef INTLV_FLUSH_EN
    // FLUSH pads with zeros and DRAIN only reads; the flush request cycle itself takes no data
    if (state_q == FLUSH) begin
      wr = 1'b1;
      wbit = 1'b0;
      emit = primed_q;
      adv = 1'b1;
    end else if (state_q == DRAIN) begin
      wr = 1'b0;
      emit = 1'b1;
      adv = 1'b1;
    end else if (flush) begin
      wr = 1'b0;
      emit = 1'b0;
      adv = 1'b0;
    end
`endif
    bank_d = bank_q;
    if (wr) bank_d[wsel_q][wcnt_q] = wbit;
    out_valid_d = emit;
    out_sof_d = emit && wcnt_q == '0;
    out_bit_d = emit ? bank_q[~wsel_q][raddr] : out_bit_q;
    wcnt_d = adv ? (last ? '0 : wcnt_q + CW'(1)) : wcnt_q;
    wsel_d = wsel_q ^ (wr && last);
    primed_d = primed_q | (wr && last);
    state_d = (wr && last) ? STREAM : state_q;
`ifdef INTLV_FLUSH_EN
    if (state_q == FLUSH && last) state_d = DRAIN;
    if (state_q == DRAIN && last) begin
      state_d = EMPTY;
      primed_d = 1'b0;
    end
    if ((state_q == EMPTY || state_q == STREAM) && flush)
      state_d = wcnt_q != '0 ? FLUSH : primed_q ? DRAIN : EMPTY;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= EMPTY;
      bank_q <= '0;
      wcnt_q <= '0;
      wsel_q <= 1'b0;
      primed_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
      out_sof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      wcnt_q <= wcnt_d;
      wsel_q <= wsel_d;
      primed_q <= primed_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
      out_sof_q <= out_sof_d;
    end
  assign out_valid = out_valid_q;
  assign out_bit = out_bit_q;
  assign out_sof = out_sof_q;
  assign primed = primed_q;
endmodule

// File: tb/tb_block_interleaver.sv
// tb_block_interleaver: random-stimulus scoreboard bench for 4x4 and 2x8 interleavers.
module tb_block_interleaver;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
  logic a_valid, a_bit, a_sof, a_primed, b_valid, b_bit, b_sof, b_primed;
`ifdef INTLV_FLUSH_EN
  logic a_rdy, b_rdy;
`endif
  int checks = 0, failures = 0, acc = 0;
  bit stream[$];
  logic [1:0] qa[$], qb[$];
  always #5 clk = ~clk;
  block_interleaver dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
`ifdef INTLV_FLUSH_EN
    .flush(1'b0), .in_ready(a_rdy),
`endif
    .out_valid(a_valid), .out_bit(a_bit), .out_sof(a_sof), .primed(a_primed)
  );
  block_interleaver #(.ROWS(2), .COLS(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
`ifdef INTLV_FLUSH_EN
    .flush(1'b0), .in_ready(b_rdy),
`endif
    .out_valid(b_valid), .out_bit(b_bit), .out_sof(b_sof), .primed(b_primed)
  );
  function automatic int ra(input int k, input int r, input int c);
    return (k % r) * c + k / r;
  endfunction
  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask
  // Output j of the stream is bit ra(j%N) of the block preceding input j's block
  task automatic send(input logic v, input logic b);
    int j, k, base;
    in_valid = v;
    in_bit = b;
    @(posedge clk);
    #1;
    if (v) begin
      j = acc;
      stream.push_back(b);
      if (j >= N) begin
        k = j % N;
        base = (j / N - 1) * N;
        qa.push_back({k == 0, stream[base + ra(k, 4, 4)]});
        qb.push_back({k == 0, stream[base + ra(k, 2, 8)]});
      end
      acc++;
    end
  endtask
  task automatic send_word(input logic [15:0] w, input int gap_mode);
    for (int i = 0; i < N; i++) begin
      send(1'b1, w[i]);
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))
        send(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask
  always @(negedge clk) begin
    logic [1:0] ea, eb;
    ea = 2'b00;
    eb = 2'b00;
    check("a_valid", a_valid, qa.size() != 0);
    check("b_valid", b_valid, qb.size() != 0);
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      check("a_bit", a_bit, ea[0]);
    end
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      check("b_bit", b_bit, eb[0]);
    end
    check("a_sof", a_sof, ea[1]);
    check("b_sof", b_sof, eb[1]);
    check("a_primed", a_primed, acc >= N);
    check("b_primed", b_primed, acc >= N);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_bit", a_bit, 1'b0);
    check("rst_a_sof", a_sof, 1'b0);
    check("rst_a_primed", a_primed, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    @(negedge clk) rst = 1'b1;
    send_word(16'h0002, 0);
    send_word(16'h0000, 0);
    send_word(16'hA5C3, 0);
    send_word(16'hFFFF, 0);
    send_word(16'($urandom), 1);
    send_word(16'($urandom), 1);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 2);
    for (int i = 0; i < 7; i++) send(1'b1, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_a_valid", a_valid, 1'b0);
    check("mid_rst_a_bit", a_bit, 1'b0);
    check("mid_rst_a_sof", a_sof, 1'b0);
    check("mid_rst_a_primed", a_primed, 1'b0);
    check("mid_rst_b_valid", b_valid, 1'b0);
    check("mid_rst_b_primed", b_primed, 1'b0);
    qa.delete();
    qb.delete();
    stream.delete();
    acc = 0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 2);
    repeat (3) send(1'b0, 1'b0);
    check("a_drained", qa.size() == 0, 1'b1);
    check("b_drained", qb.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
